// File: rtl/vdot_seq_ctrl_if.sv
// Pipeline <-> VDOT sequencer connection: EX-stage instruction info in,
// stall / latch-enable / result path out.
interface vdot_seq_ctrl_if;
    logic        is_vdot;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        ext_stall;
    logic        flush;
    logic        stall_out;
    logic        ex_wb_en;
    logic [31:0] vdot_out;
    logic        vdot_valid;
    logic        busy;

    // The pipeline side drives the instruction and control inputs.
    modport master (
        output is_vdot, opA, opB, ext_stall, flush,
        input  stall_out, ex_wb_en, vdot_out, vdot_valid, busy
    );

    modport slave (
        input  is_vdot, opA, opB, ext_stall, flush,
        output stall_out, ex_wb_en, vdot_out, vdot_valid, busy
    );
endinterface

// File: rtl/vdot_seq_ctrl.sv
// Multi-cycle VDOT sequencer: stalls the front end, runs one signed lane MAC
// per cycle, then presents the sign-extended sum to the EX/WB latch.
module vdot_seq_ctrl #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    vdot_seq_ctrl_if.slave  bus
);
    localparam int PROD_W = 2 * LANE_W;
    localparam int ACC_W  = PROD_W + $clog2(LANES);
    localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic signed [ACC_W-1:0]         acc;
    logic [LANES-1:0][LANE_W-1:0]    a_q;
    logic [LANES-1:0][LANE_W-1:0]    b_q;
    logic [31:0]                     vdot_q;

    logic signed [PROD_W-1:0]        prod;
    logic signed [ACC_W-1:0]         acc_next;
    logic                            last_lane;
    logic                            stall;
    logic                            valid;

    assign prod      = $signed(a_q[cnt]) * $signed(b_q[cnt]);
    assign acc_next  = acc + ACC_W'(prod);
    assign last_lane = (cnt == CNT_W'(LANES - 1));

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        stall = 1'b0;
        valid = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE:    stall = bus.is_vdot;
                CALC:    stall = ~bus.flush;
                DONE:    valid = ~bus.ext_stall & ~bus.flush;
                default: ;
            endcase
        end
    end

    assign bus.stall_out  = stall;
    assign bus.vdot_valid = valid;
    assign bus.ex_wb_en   = ~rst & ~stall & ~bus.ext_stall;
    assign bus.busy       = (state != IDLE);
    assign bus.vdot_out   = vdot_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            vdot_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.is_vdot && !bus.flush && !bus.ext_stall) begin
                        a_q   <= bus.opA;
                        b_q   <= bus.opB;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // flush wins over ext_stall: the partial sum is simply dropped
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (!bus.ext_stall) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last_lane) begin
                            vdot_q <= 32'(acc_next);
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.flush || !bus.ext_stall) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vdot_seq_ctrl.sv
// Self-checking bench for vdot_seq_ctrl: directed cases with literal results
// plus randomized traffic compared every cycle against a behavioural model.
module tb_vdot_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    vdot_seq_ctrl_if bus();

    vdot_seq_ctrl #(.LANES(4), .LANE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole dot product in one go, as plain integer arithmetic.
    function automatic int dot(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++)
            s += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
        return s;
    endfunction

    // Behavioural model: an operation is active, has processed m_lanes lanes,
    // and is in its result phase once all four lanes have been consumed.
    bit m_active = 0;
    int m_lanes  = 0;
    int m_pend   = 0;
    int m_out    = 0;

    always @(negedge clk) begin
        logic e_stall, e_valid, e_wb, e_busy;
        logic [31:0] e_out;
        bit in_result;
        in_result = m_active && (m_lanes == 4);
        if (rst)             e_stall = 1'b0;
        else if (!m_active)  e_stall = bus.is_vdot;
        else if (!in_result) e_stall = !bus.flush;
        else                 e_stall = 1'b0;
        e_valid = !rst && in_result && !bus.ext_stall && !bus.flush;
        e_wb    = !rst && !e_stall && !bus.ext_stall;
        e_busy  = !rst && m_active;
        e_out   = rst ? 32'd0 : m_out;
        check("stall_out",  {31'd0, bus.stall_out},  {31'd0, e_stall});
        check("vdot_valid", {31'd0, bus.vdot_valid}, {31'd0, e_valid});
        check("ex_wb_en",   {31'd0, bus.ex_wb_en},   {31'd0, e_wb});
        check("busy",       {31'd0, bus.busy},       {31'd0, e_busy});
        check("vdot_out",   bus.vdot_out, e_out);
        // advance the model by the coming clock edge
        if (rst) begin
            m_active = 0; m_lanes = 0; m_out = 0;
        end else if (!m_active) begin
            if (bus.is_vdot && !bus.flush && !bus.ext_stall) begin
                m_active = 1; m_lanes = 0; m_pend = dot(bus.opA, bus.opB);
            end
        end else if (bus.flush) begin
            m_active = 0;
        end else if (!bus.ext_stall) begin
            if (in_result) m_active = 0;
            else begin
                m_lanes++;
                if (m_lanes == 4) m_out = m_pend;
            end
        end
    end

    // One VDOT with is_vdot held until its result strobe; optional ext_stall
    // burst starting at relative cycle stall_at.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stall_at, input int stall_len,
                          output logic [31:0] res, output int occ, output int st_cnt);
        bit got = 0;
        res = '0; occ = 0; st_cnt = 0;
        @(posedge clk); #1;
        bus.is_vdot = 1'b1; bus.opA = a; bus.opB = b;
        for (int k = 0; k < 40; k++) begin
            bus.ext_stall = (k >= stall_at) && (k < stall_at + stall_len);
            @(negedge clk);
            occ++;
            if (bus.stall_out) st_cnt++;
            if (bus.vdot_valid) begin
                res = bus.vdot_out;
                check("ex_wb_en_at_valid", {31'd0, bus.ex_wb_en}, 32'd1);
                got = 1;
                break;
            end
            @(posedge clk); #1;
            bus.opA = $urandom; bus.opB = $urandom;  // must be ignored mid-op
        end
        if (!got) check("op_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.is_vdot = 1'b0; bus.ext_stall = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int occ, st;
        int v_k[2];
        logic [31:0] v_r[2];
        int nv;
        int bad_valid;

        bus.is_vdot = 0; bus.opA = 0; bus.opB = 0; bus.ext_stall = 0; bus.flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vdot_out", bus.vdot_out, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ex_wb_en", {31'd0, bus.ex_wb_en}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ex_wb_en", {31'd0, bus.ex_wb_en}, 32'd1);

        run_op(32'h01020304, 32'h01010101, 100, 0, res, occ, st);
        check("case1_res", res, 32'h0000000A);
        check("case1_occ", occ, 6);
        check("case1_stall_cycles", st, 5);
        run_op(32'hFFFFFFFF, 32'h7F7F7F7F, 100, 0, res, occ, st);
        check("case2_res", res, 32'hFFFFFE04);
        run_op(32'h80808080, 32'h80808080, 100, 0, res, occ, st);
        check("case3a_res", res, 32'h00010000);
        run_op(32'h7F7F7F7F, 32'h80808080, 100, 0, res, occ, st);
        check("case3b_res", res, 32'hFFFF0200);
        run_op(32'h01020304, 32'h01010101, 3, 3, res, occ, st);
        check("stall_res", res, 32'h0000000A);
        check("stall_occ", occ, 9);
        check("stall_stall_cycles", st, 8);

        // flush in the second CALC cycle
        @(posedge clk); #1;
        bus.is_vdot = 1; bus.opA = 32'h02020202; bus.opB = 32'h03030303;
        bad_valid = 0;
        repeat (2) begin
            @(negedge clk); if (bus.vdot_valid) bad_valid++;
            @(posedge clk); #1;
        end
        bus.flush = 1;
        @(negedge clk);
        check("flush_stall_out", {31'd0, bus.stall_out}, 32'd0);
        if (bus.vdot_valid) bad_valid++;
        @(posedge clk); #1;
        bus.flush = 0; bus.is_vdot = 0;
        @(negedge clk);
        check("flush_busy_next", {31'd0, bus.busy}, 32'd0);
        repeat (4) begin
            @(negedge clk); if (bus.vdot_valid) bad_valid++;
        end
        check("flush_no_valid", bad_valid, 0);
        check("flush_vdot_out_kept", bus.vdot_out, 32'h0000000A);

        // reset in the middle of CALC
        @(posedge clk); #1;
        bus.is_vdot = 1; bus.opA = 32'h02020202; bus.opB = 32'h03030303;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("midrst_stall_out", {31'd0, bus.stall_out}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_valid", {31'd0, bus.vdot_valid}, 32'd0);
        check("midrst_ex_wb_en", {31'd0, bus.ex_wb_en}, 32'd0);
        check("midrst_vdot_out", bus.vdot_out, 32'd0);
        @(posedge clk); #1;
        rst = 0; bus.is_vdot = 0;

        // back-to-back VDOTs
        @(posedge clk); #1;
        bus.is_vdot = 1; bus.opA = 32'h01020304; bus.opB = 32'h01010101;
        nv = 0; v_k[0] = 0; v_k[1] = 0; v_r[0] = 0; v_r[1] = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.vdot_valid) begin v_k[nv] = k; v_r[nv] = bus.vdot_out; nv++; end
            if (nv == 2) break;
            @(posedge clk); #1;
            if (nv == 1) begin bus.opA = 32'h02020202; bus.opB = 32'h03030303; end
        end
        check("b2b_count", nv, 2);
        check("b2b_gap", v_k[1] - v_k[0], 6);
        check("b2b_res0", v_r[0], 32'h0000000A);
        check("b2b_res1", v_r[1], 32'h00000018);
        @(posedge clk); #1;
        bus.is_vdot = 0;

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            bus.is_vdot   = ($urandom_range(0, 99) < 60);
            bus.opA       = $urandom;
            bus.opB       = $urandom;
            bus.ext_stall = ($urandom_range(0, 99) < 20);
            bus.flush     = ($urandom_range(0, 99) < 5);
        end
        @(posedge clk); #1;
        bus.is_vdot = 0; bus.ext_stall = 0; bus.flush = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vdot_seq_ctrl.md
Name: vdot_seq_ctrl

Overview:
- Multi-cycle sequencer for the VDOT (packed signed dot-product) instruction in the EX stage.
- On a VDOT in EX, the block stalls the front of the pipeline and runs one lane MAC per cycle.
- When the result is ready it drives it onto the VDOT result path into the EX/WB latch.
- It generates the EX/WB latch enable and a one-cycle result-valid strobe.

Parameters:
LANES, 4, number of packed lanes per 32-bit operand (LANES*LANE_W = 32)
LANE_W, 8, signed lane width in bits

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
is_vdot  input  1  instruction currently in EX is VDOT
opA  input  32  operand A, LANES packed signed lanes, lane 0 = bits [LANE_W-1:0]
opB  input  32  operand B, same packing
ext_stall  input  1  downstream/memory stall; freezes sequencer and EX/WB
flush  input  1  squash EX instruction (branch/exception)
stall_out  output  1  hold PC, IF/ID and ID/EX latches
ex_wb_en  output  1  enable for EX/WB latch
vdot_out  output  32  registered dot-product result, sign-extended
vdot_valid  output  1  result present on vdot_out this cycle and EX/WB captures it
busy  output  1  sequencer not in IDLE

Behaviour:
- Single clock domain; reset asynchronous, active-high.
- Reset: state=IDLE, cnt=0, acc=0, vdot_out=0, captured operands=0.
- While rst is high, stall_out, ex_wb_en, vdot_valid and busy are all 0.
- States:
  - IDLE: is_vdot & ~flush & ~ext_stall -> latch opA/opB, acc=0, cnt=0, go CALC. stall_out=is_vdot (combinational, same cycle).
  - CALC: stall_out=1. If ~ext_stall: acc += sext(A[cnt])*sext(B[cnt]), cnt++. Update with cnt==LANES-1 -> write final sum to vdot_out, go DONE. ext_stall=1 -> acc/cnt hold.
  - DONE: stall_out=0. If ~ext_stall: vdot_valid=1, go IDLE. ext_stall=1 -> remain DONE, vdot_valid=0.
- ex_wb_en = ~stall_out & ~ext_stall, in all states.
- Arithmetic:
  - Product is 2*LANE_W signed; accumulator is 2*LANE_W+clog2(LANES) bits (18 for defaults).
  - Result is sign-extended to 32 bits; no saturation; overflow is impossible by sizing.
- Latency: VDOT occupies EX for LANES+2 cycles (1 IDLE + LANES CALC + 1 DONE) with no ext_stall; stall_out is high for LANES+1 cycles.
- vdot_out holds its value until the next VDOT completes. Non-VDOT instructions do not change it.
- flush:
  - In CALC or DONE: go IDLE next cycle, no vdot_valid, vdot_out unchanged; stall_out=0 in the flush cycle.
  - In IDLE: suppresses the start.
  - flush has priority over ext_stall.
- Operand capture happens only at IDLE->CALC; opA/opB changes during CALC are ignored.
- Back-to-back VDOT: the DONE->IDLE cycle releases the stall; the next VDOT in EX starts from IDLE on the following cycle.
- ext_stall in IDLE with is_vdot: stall_out=1, no transition until ext_stall drops.
- rst asserted mid-operation: immediate return to reset values; partial result is discarded.
- busy = (state != IDLE).

Test Plan:
- opA=0x01020304, opB=0x01010101, is_vdot held -> stall_out high 5 cycles, DONE cycle vdot_out=0x0000000A, vdot_valid=1, ex_wb_en=1.
- opA=0xFFFFFFFF, opB=0x7F7F7F7F -> vdot_out=0xFFFFFE04 (-508).
- opA=opB=0x80808080 -> vdot_out=0x00010000 (no overflow); then opA=0x7F7F7F7F, opB=0x80808080 -> 0xFFFF0200.
- ext_stall pulsed 3 cycles during CALC (cnt=2) of case 1 -> total EX occupancy 9 cycles, result still 0x0A, ex_wb_en=0 while stalled.
- flush in 2nd CALC cycle -> IDLE next cycle, vdot_valid never asserts, vdot_out keeps previous value; rst mid-CALC -> all outputs 0 immediately.
- Two VDOTs back-to-back (0x01020304·0x01010101, then 0x02020202·0x03030303) -> valid strobes 6 cycles apart, results 0x0A then 0x18.
